// File: rtl/program_counter.sv
// Registered program counter for the instruction sequencer.
// Per edge: load a branch/jump target, step by one, or hold; reset forces RESET_ADDR.
module program_counter #(
    parameter int unsigned           WIDTH      = 12,
    parameter logic [WIDTH-1:0]      RESET_ADDR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             loadPC,
    input  logic             incPC,
    input  logic [WIDTH-1:0] address,
    output logic [WIDTH-1:0] execadd
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    // Load outranks increment; the increment wraps modulo 2^WIDTH.
    always_comb begin
        pc_d = pc_q;
        if (loadPC) begin
            pc_d = address;
        end else if (incPC) begin
            pc_d = pc_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign execadd = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: vector table for single-edge behaviour,
// hand sequences for asynchronous reset and between-edge input changes.
module tb_program_counter;

    localparam int W = 12;

    logic         clk;
    logic         rst;
    logic         loadPC;
    logic         incPC;
    logic [W-1:0] address;
    logic [W-1:0] execadd;

    int checks = 0;
    int errors = 0;

    program_counter #(.WIDTH(W), .RESET_ADDR(12'h000)) dut (
        .clk     (clk),
        .rst     (rst),
        .loadPC  (loadPC),
        .incPC   (incPC),
        .address (address),
        .execadd (execadd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         ld;
        logic         inc;
        logic [W-1:0] addr;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic ld, input logic inc,
                       input logic [W-1:0] addr, input logic [W-1:0] exp);
        vec_t v;
        v.name = name; v.ld = ld; v.inc = inc; v.addr = addr; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: execadd=%03h expected=%03h", name, got, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic ld, input logic inc, input logic [W-1:0] addr);
        @(negedge clk);
        loadPC  = ld;
        incPC   = inc;
        address = addr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; loadPC = 1'b0; incPC = 1'b0; address = 12'h000;

        add("idle0",     0, 0, 12'h000, 12'h000);
        add("idle1",     0, 0, 12'h001, 12'h000);
        add("idle2",     0, 0, 12'h002, 12'h000);
        add("idle3",     0, 0, 12'h003, 12'h000);
        add("load3",     1, 0, 12'h003, 12'h003);
        add("hold3",     0, 0, 12'h7AB, 12'h003);
        add("inc4",      0, 1, 12'h111, 12'h004);
        add("inc5",      0, 1, 12'h222, 12'h005);
        add("inc6",      0, 1, 12'h333, 12'h006);
        add("inc7",      0, 1, 12'h444, 12'h007);
        add("hold7a",    0, 0, 12'h555, 12'h007);
        add("hold7b",    0, 0, 12'hABC, 12'h007);
        add("load050",   1, 0, 12'h050, 12'h050);
        add("prio123",   1, 1, 12'h123, 12'h123);
        add("hold123",   0, 0, 12'h999, 12'h123);
        add("loadFFE",   1, 0, 12'hFFE, 12'hFFE);
        add("incFFF",    0, 1, 12'h000, 12'hFFF);
        add("wrap000",   0, 1, 12'h000, 12'h000);
        add("wrap001",   0, 1, 12'h000, 12'h001);
        add("lvl_ld_a",  1, 0, 12'h010, 12'h010);
        add("lvl_ld_b",  1, 0, 12'h011, 12'h011);
        add("lvl_ld_c",  1, 1, 12'h800, 12'h800);

        // Reset state, including edges while reset is held with requests pending.
        #2;
        check("reset_async_t0", execadd, 12'h000);
        @(negedge clk); loadPC = 1'b1; incPC = 1'b1; address = 12'h5A5;
        @(posedge clk); #1;
        check("reset_held_edge", execadd, 12'h000);
        @(negedge clk); rst = 1'b0; loadPC = 1'b0; incPC = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].ld, vecs[i].inc, vecs[i].addr);
            check(vecs[i].name, execadd, vecs[i].exp);
        end

        // Inputs changing between edges must not reach execadd.
        step(1'b1, 1'b0, 12'h0F0);
        check("pre_midcycle", execadd, 12'h0F0);
        address = 12'h3C3; incPC = 1'b1;
        #2;
        check("no_comb_path", execadd, 12'h0F0);

        // Async reset during an increment run at 0x2A0.
        step(1'b1, 1'b0, 12'h29E);
        step(1'b0, 1'b1, 12'h000);
        step(1'b0, 1'b1, 12'h000);
        check("run_at_2A0", execadd, 12'h2A0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_mid", execadd, 12'h000);
        @(posedge clk); #1;
        check("rst_held_inc", execadd, 12'h000);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("release_inc001", execadd, 12'h001);
        step(1'b0, 1'b1, 12'h000);
        check("release_inc002", execadd, 12'h002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
